scoreboard_ctrl: RTL
====================

SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

Interface
REQ-001 Parameter: LOCKOUT_CYCLES, 4, number of idle cycles after any accepted command (legal range 1..255).
REQ-002 Parameter: CONFIRM_CYCLES, 1000, window in cycles for a second btnC pulse to confirm a clear (legal range 2..2^20-1).
REQ-003 Port: clk  input  1  clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: inc_pulse  input  1  single-cycle, synchronized increment request (button A).
REQ-006 Port: dec_pulse  input  1  single-cycle, synchronized decrement request (button B).
REQ-007 Port: clr_pulse  input  1  single-cycle, synchronized clear request (button C).
REQ-008 Port: score_tens  output  4  registered BCD tens digit, 0..9.
REQ-009 Port: score_ones  output  4  registered BCD ones digit, 0..9.
REQ-010 Port: score_changed  output  1  registered one-cycle pulse, high in the first cycle a new score value appears.
REQ-011 Port: clr_armed  output  1  registered, high while the FSM is in ARMED.
REQ-012 Port: busy  output  1  registered, high while the FSM is in LOCKOUT.

Function
REQ-013 FSM states: IDLE, ARMED, LOCKOUT; the encoding is the package enum.
REQ-014 Command priority within one cycle: clr_pulse > inc_pulse > dec_pulse; lower-priority pulses in the same cycle are discarded.
REQ-015 IDLE: inc -> score+1, go LOCKOUT; dec -> score-1, go LOCKOUT; clr -> go ARMED, load confirm counter with CONFIRM_CYCLES-1, score unchanged.
REQ-016 ARMED: clr -> score := 00, go LOCKOUT; inc/dec -> disarm, apply inc/dec, go LOCKOUT; counter reaches 0 with no pulse -> go IDLE, no score change.
REQ-017 LOCKOUT: load lockout counter with LOCKOUT_CYCLES-1 on entry; ignore all pulses; go IDLE in the cycle after the counter reaches 0, so busy is high for exactly LOCKOUT_CYCLES cycles.
REQ-018 Latency: score and score_changed update on the clock edge that samples the accepted pulse (one cycle after the pulse is presented).
REQ-019 Arithmetic is two-digit BCD: ones 9+1 -> 0 with carry into tens; ones 0-1 -> 9 with borrow from tens; digits never leave 0..9.
REQ-020 score_changed asserts only if the stored value actually differs (clear from 00 gives no pulse but still enters LOCKOUT).
REQ-021 Inputs with a high level longer than one cycle are treated as one pulse per high cycle; no edge detection is done in this block.

Reset
REQ-022 Asserting reset at any time, including mid-LOCKOUT or mid-ARMED, forces: state IDLE, score 00, both counters 0, score_changed 0, clr_armed 0, busy 0.
REQ-023 On the first edge after reset deasserts, pulses are accepted normally.

Configuration
REQ-024 Macro SCOREBOARD_SATURATE_EN defined: 99+1 stays 99 and 00-1 stays 00, with no score_changed but still entering LOCKOUT.
REQ-025 Macro SCOREBOARD_SATURATE_EN undefined: 99+1 wraps to 00 and 00-1 wraps to 99, each with a score_changed pulse.

Structure
REQ-026 Shared package scoreboard_pkg holds the state enum, the typedef bcd_digit_t (4-bit), and the constants BCD_MAX_DIGIT=9 and SCORE_MAX=99 (BCD 8'h99).
REQ-027 One sub-module, bcd_updown2, implements combinational two-digit BCD +1/-1 with wrap/saturate selection; the FSM, counters and output registers live in scoreboard_ctrl.

Verification
REQ-028 Reset, then inc pulse -> next edge score 01, score_changed high for 1 cycle, busy high for 4 cycles; an inc during busy -> ignored, score stays 01.
REQ-029 Score 09 + inc -> 10; score 10 + dec -> 09; score 99 + inc -> 00 (wrap build) or 99 with no score_changed (saturate build).
REQ-030 Score 42, clr pulse -> clr_armed high, score 42; second clr 10 cycles later -> score 00, score_changed pulse, busy for 4 cycles.
REQ-031 Score 42, clr pulse, then no pulse for CONFIRM_CYCLES cycles -> clr_armed drops, score 42, no score_changed.
REQ-032 inc, dec and clr pulses in the same cycle from IDLE -> ARMED only; inc and dec in the same cycle -> score+1.
REQ-033 Async reset asserted mid-ARMED and mid-LOCKOUT -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the two-digit BCD scoreboard controller.
package scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t  BCD_MAX_DIGIT = 4'd9;
    localparam logic [7:0]  SCORE_MAX     = 8'h99;

endpackage

// File: rtl/bcd_updown2.sv
// Combinational two-digit BCD +1/-1.
// Build option SCOREBOARD_SATURATE_EN: when defined, 99+1 and 00-1 hold their
// value; otherwise they wrap to 00 and 99 respectively.
module bcd_updown2
    import scoreboard_pkg::*;
(
    input  bcd_digit_t tens_i,
    input  bcd_digit_t ones_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output bcd_digit_t tens_o,
    output bcd_digit_t ones_o
);

`ifdef SCOREBOARD_SATURATE_EN
    localparam logic SATURATE = 1'b1;
`else
    localparam logic SATURATE = 1'b0;
`endif

    // Next digits; increment wins over decrement, no request passes the value through.
    always_comb begin
        tens_o = tens_i;
        ones_o = ones_i;
        if (inc_i) begin
            if (ones_i >= BCD_MAX_DIGIT) begin
                if (tens_i >= BCD_MAX_DIGIT) begin
                    if (!SATURATE) begin
                        tens_o = '0;
                        ones_o = '0;
                    end
                end else begin
                    tens_o = tens_i + 4'd1;
                    ones_o = '0;
                end
            end else begin
                ones_o = ones_i + 4'd1;
            end
        end else if (dec_i) begin
            if (ones_i == '0) begin
                if (tens_i == '0) begin
                    if (!SATURATE) begin
                        {tens_o, ones_o} = SCORE_MAX;
                    end
                end else begin
                    tens_o = tens_i - 4'd1;
                    ones_o = BCD_MAX_DIGIT;
                end
            end else begin
                ones_o = ones_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/scoreboard_ctrl.sv
// Two-digit BCD scoreboard with inc/dec buttons, two-press confirmed clear and
// a post-command lockout. Build option SCOREBOARD_SATURATE_EN selects
// saturating instead of wrapping arithmetic (handled in bcd_updown2).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a command
// ST_ARMED   | first clear seen; second clear within the window zeroes score
// ST_LOCKOUT | command just accepted; all pulses ignored until timer expires
module scoreboard_ctrl
    import scoreboard_pkg::*;
#(
    parameter int unsigned LOCKOUT_CYCLES = 4,
    parameter int unsigned CONFIRM_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_pulse,
    input  logic       dec_pulse,
    input  logic       clr_pulse,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic       score_changed,
    output logic       clr_armed,
    output logic       busy
);

    localparam logic [7:0]  LOCK_LOAD = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [19:0] CONF_LOAD = 20'(CONFIRM_CYCLES - 1);

    state_e      state_q, state_d;
    bcd_digit_t  tens_q, tens_d;
    bcd_digit_t  ones_q, ones_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic [19:0] conf_cnt_q, conf_cnt_d;
    logic        changed_q, armed_q, busy_q;

    bcd_digit_t  upd_tens, upd_ones;

    bcd_updown2 u_bcd (
        .tens_i (tens_q),
        .ones_i (ones_q),
        .inc_i  (inc_pulse),
        .dec_i  (dec_pulse),
        .tens_o (upd_tens),
        .ones_o (upd_ones)
    );

    // Next state, score and timers; clear outranks inc, inc outranks dec.
    always_comb begin
        state_d    = state_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        lock_cnt_d = lock_cnt_q;
        conf_cnt_d = conf_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_pulse) begin
                    state_d    = ST_ARMED;
                    conf_cnt_d = CONF_LOAD;
                end else if (inc_pulse || dec_pulse) begin
                    tens_d     = upd_tens;
                    ones_d     = upd_ones;
                    state_d    = ST_LOCKOUT;
                    lock_cnt_d = LOCK_LOAD;
                end
            end
            ST_ARMED: begin
                if (clr_pulse) begin
                    tens_d     = '0;
                    ones_d     = '0;
                    state_d    = ST_LOCKOUT;
                    lock_cnt_d = LOCK_LOAD;
                end else if (inc_pulse || dec_pulse) begin
                    tens_d     = upd_tens;
                    ones_d     = upd_ones;
                    state_d    = ST_LOCKOUT;
                    lock_cnt_d = LOCK_LOAD;
                end else if (conf_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    conf_cnt_d = conf_cnt_q - 20'd1;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, score, timers and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tens_q     <= '0;
            ones_q     <= '0;
            lock_cnt_q <= '0;
            conf_cnt_q <= '0;
            changed_q  <= 1'b0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            lock_cnt_q <= lock_cnt_d;
            conf_cnt_q <= conf_cnt_d;
            changed_q  <= ({tens_d, ones_d} != {tens_q, ones_q});
            armed_q    <= (state_d == ST_ARMED);
            busy_q     <= (state_d == ST_LOCKOUT);
        end
    end

    assign score_tens    = tens_q;
    assign score_ones    = ones_q;
    assign score_changed = changed_q;
    assign clr_armed     = armed_q;
    assign busy          = busy_q;

endmodule
